// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
// The requesters drive req/wdata; the arbiter returns the grant, owner and register contents.
interface dff_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [IW-1:0]          owner;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;

  modport master (
    output req, wdata,
    input  gnt, owner, busy, q, q_valid
  );

  modport slave (
    input  req, wdata,
    output gnt, owner, busy, q, q_valid
  );
endinterface

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit holding register among N_REQ requesters.
// A tenure ends when the owner drops req or after MAX_HOLD granted cycles; the next
// grantee is chosen at that same edge, so back-to-back tenures have no idle gap.
module dff_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  dff_reg_arbiter_if.slave   bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM  = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             req_own;
  logic             arb_go;
  logic [IW-1:0]    pick;

  // First requesting index after base, wrapping; base itself is checked last so a
  // lone requester at its hold limit is re-granted.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    base);
    logic [IW-1:0] sel;
    logic [IW-1:0] cand;
    sel = base;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(base) + k) % N_REQ);
      if (r[cand]) sel = cand;
    end
    return sel;
  endfunction

  // Next-state: arbitration, register load, hold counting and tenure release.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    arb_go    = 1'b0;
    req_own   = bus.req[owner_q];
    pick      = rr_pick(bus.req, last_q);

    unique case (state_q)
      IDLE: begin
        if (|bus.req) arb_go = 1'b1;
      end
      GRANT: begin
        if (req_own) begin
          q_d       = bus.wdata[owner_q*WIDTH +: WIDTH];
          q_valid_d = 1'b1;
        end
        if (!req_own || hold_q == HOLD_LIM) begin
          if (|bus.req) begin
            arb_go = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (arb_go) begin
      state_d = GRANT;
      gnt_d   = N_REQ'(1) << pick;
      owner_d = pick;
      last_d  = pick;
      hold_d  = HW'(1);
    end
  end

  // State and output registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= LAST_INIT;
      hold_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = |gnt_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed bench for dff_reg_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
module tb_dff_reg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  dff_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  dff_reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [7:0] qq,
                           input logic qv);
    check({tag, ".gnt"},  32'(bus.gnt),     32'(g));
    check({tag, ".busy"}, 32'(bus.busy),    32'(|g));
    check({tag, ".q"},    32'(bus.q),       32'(qq));
    check({tag, ".qv"},   32'(bus.q_valid), 32'(qv));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   order [4] = '{0, 1, 3, 0};
    logic [7:0] wd [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

    bus.req   = '0;
    bus.wdata = '0;

    // Reset state
    tick();
    check_out("reset", 4'b0000, 8'h00, 1'b0);
    check("reset.owner", 32'(bus.owner), 32'd0);
    rst = 1'b0;
    tick();
    check_out("idle", 4'b0000, 8'h00, 1'b0);

    // Single requester 2
    bus.req = 4'b0100;
    bus.wdata[2*8 +: 8] = 8'hA5;
    tick();
    check_out("single.grant", 4'b0100, 8'h00, 1'b0);
    check("single.owner", 32'(bus.owner), 32'd2);
    tick();
    check_out("single.load1", 4'b0100, 8'hA5, 1'b1);
    tick();
    check_out("single.load2", 4'b0100, 8'hA5, 1'b1);
    bus.req = 4'b0000;
    tick();
    check_out("single.rel", 4'b0000, 8'hA5, 1'b0);
    check("single.owner_hold", 32'(bus.owner), 32'd2);

    // Early release of requester 1, hand-off to requester 2
    bus.req = 4'b0010;
    bus.wdata[1*8 +: 8] = 8'h11;
    tick();
    check_out("handoff.g1", 4'b0010, 8'hA5, 1'b0);
    bus.req = 4'b0110;
    bus.wdata[2*8 +: 8] = 8'h22;
    tick();
    check_out("handoff.l1", 4'b0010, 8'h11, 1'b1);
    tick();
    check_out("handoff.l2", 4'b0010, 8'h11, 1'b1);
    bus.req = 4'b0100;
    bus.wdata[1*8 +: 8] = 8'hEE;
    tick();
    check_out("handoff.g2", 4'b0100, 8'h11, 1'b0);
    check("handoff.owner", 32'(bus.owner), 32'd2);
    tick();
    check_out("handoff.l3", 4'b0100, 8'h22, 1'b1);
    bus.req = 4'b0000;
    tick();
    check_out("handoff.idle", 4'b0000, 8'h22, 1'b0);

    // Reset mid-tenure with all requesting
    bus.req   = 4'b1111;
    bus.wdata = {wd[3], wd[2], wd[1], wd[0]};
    tick();
    check_out("rstmid.g3", 4'b1000, 8'h22, 1'b0);
    tick();
    check_out("rstmid.l3", 4'b1000, 8'h43, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_out("rstmid.async", 4'b0000, 8'h00, 1'b0);
    check("rstmid.owner", 32'(bus.owner), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_out("rstmid.first", 4'b0001, 8'h00, 1'b0);

    // Round robin over 1011 with 4-cycle tenures
    bus.req = 4'b1011;
    for (int k = 1; k < 16; k++) begin
      tick();
      check_out($sformatf("rr.k%0d", k), 4'(32'(1) << order[k/4]), wd[order[(k-1)/4]], 1'b1);
    end
    bus.req = 4'b0000;
    tick();
    check_out("rr.idle", 4'b0000, 8'h10, 1'b0);
    check("rr.owner", 32'(bus.owner), 32'd0);

    // Lone requester at the hold limit
    bus.req = 4'b0001;
    tick();
    check_out("lone.grant", 4'b0001, 8'h10, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      bus.wdata[7:0] = 8'(8'h50 + j);
      tick();
      check_out($sformatf("lone.j%0d", j), 4'b0001, 8'(8'h50 + j), 1'b1);
    end
    bus.req = 4'b0000;
    tick();
    check_out("lone.idle", 4'b0000, 8'h5A, 1'b0);

    // Wrap-around priority from last owner 3
    bus.req = 4'b1000;
    tick();
    check("wrap.g3", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0000;
    tick();
    check("wrap.idle", 32'(bus.gnt), 32'h0);
    check("wrap.owner", 32'(bus.owner), 32'd3);
    bus.req = 4'b1001;
    tick();
    check("wrap.g0", 32'(bus.gnt), 32'h1);
    tick();
    tick();
    tick();
    check("wrap.g0_hold", 32'(bus.gnt), 32'h1);
    tick();
    check("wrap.g3b", 32'(bus.gnt), 32'h8);
    check("wrap.owner3", 32'(bus.owner), 32'd3);
    check("wrap.q", 32'(bus.q), 32'h5A);
    bus.req = 4'b0000;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
